// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared types and constants for the mem_dma copy/fill engine.
//   state_t    : FSM state encoding (IDLE, RD, WR, FILL, DONE)
//   MODE_COPY / MODE_FILL : values of the mode command input
//   AW / DW    : default address and data widths
package mem_dma_pkg;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mem_dma_cksum.sv
// mem_dma_cksum: running mod-2^DW sum of the bytes written by mem_dma.
// Only instantiated when MEM_DMA_CHECKSUM_EN is defined.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : clear the sum (command accepted)
//   add_en     : a write commits at this edge
//   add_val    : byte being written
//   sum        : registered accumulated sum
module mem_dma_cksum
  import mem_dma_pkg::*;
#(
  parameter int unsigned DW = mem_dma_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          add_en,
  input  logic [DW-1:0] add_val,
  output logic [DW-1:0] sum
);

  logic [DW-1:0] sum_q, sum_d;

  // Clear on accept has priority; accept and a write never coincide.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + add_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mem_dma.sv
// mem_dma: byte-wise copy/fill engine mastering the data memory port.
// Optional feature macro: MEM_DMA_CHECKSUM_EN (checksum of written bytes;
// without it checksum is tied to 0).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start, mode         : command strobe (sampled in IDLE), 0 copy / 1 fill
//   src, dst, len       : source base, destination base, byte count (0 = no-op)
//   fill_val            : fill byte
//   busy, done          : transfer in progress, one-cycle completion pulse
//   checksum            : mod-2^DW sum of bytes written by the last command
//   mem_req             : memory port ownership request (== busy)
//   mem_w, mem_addr     : memory write enable and address
//   mem_wdata, mem_rdata: memory write data, combinational read data
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned AW = mem_dma_pkg::AW,
  parameter int unsigned DW = mem_dma_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum,
  output logic          mem_req,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state_q, state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] buf_q, buf_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mem_w_q, mem_w_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          accept_c;
  logic          last_c;

  assign accept_c = (state_q == S_IDLE) && start;
  assign last_c   = (AW'(cnt_q + AW'(1)) == len_q);

  // Next-state and datapath; outputs are derived from the next state so the
  // registered port values line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    buf_d       = buf_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_w_d     = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d = src;
          dst_ptr_d = dst;
          len_d     = len;
          fill_d    = fill_val;
          cnt_d     = '0;
          if (len == '0) begin
            state_d = S_DONE;
          end else if (mode == MODE_COPY) begin
            state_d = S_RD;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_RD: begin
        buf_d   = mem_rdata;
        state_d = S_WR;
      end
      S_WR: begin
        src_ptr_d = src_ptr_q + AW'(1);
        dst_ptr_d = dst_ptr_q + AW'(1);
        cnt_d     = cnt_q + AW'(1);
        state_d   = last_c ? S_DONE : S_RD;
      end
      S_FILL: begin
        dst_ptr_d = dst_ptr_q + AW'(1);
        cnt_d     = cnt_q + AW'(1);
        if (last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_RD: begin
        busy_d     = 1'b1;
        mem_addr_d = src_ptr_d;
      end
      S_WR: begin
        busy_d      = 1'b1;
        mem_w_d     = 1'b1;
        mem_addr_d  = dst_ptr_d;
        mem_wdata_d = buf_d;
      end
      S_FILL: begin
        busy_d      = 1'b1;
        mem_w_d     = 1'b1;
        mem_addr_d  = dst_ptr_d;
        mem_wdata_d = fill_d;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      fill_q      <= '0;
      buf_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_w_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      buf_q       <= buf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_w_q     <= mem_w_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign mem_req   = busy_q;
  assign done      = done_q;
  assign mem_w     = mem_w_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_DMA_CHECKSUM_EN
  // A write commits at the edge that ends a cycle with mem_w high.
  mem_dma_cksum #(
    .DW(DW)
  ) u_cksum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept_c),
    .add_en (mem_w_q),
    .add_val(mem_wdata_q),
    .sum    (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: randomized self-checking bench for mem_dma against a
// behavioural byte-array model of each copy/fill command.
module tb_mem_dma;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] src, dst, len, fill_val;
  logic       busy, done, mem_req, mem_w;
  logic [7:0] checksum, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem  [256];
  logic [7:0] refm [256];
  logic       tb_we;
  logic [7:0] tb_addr, tb_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_dma dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill_val (fill_val),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .mem_req  (mem_req),
    .mem_w    (mem_w),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: asynchronous read, write at the rising edge; bench preload port.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_w) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    refm[a] = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic cmp_mem(input string tag);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== refm[a]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_w"}, mem_w, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_cksum"}, checksum, 0);
  endtask

  // Issue one command, observe it to completion, then compare with the model.
  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] n, input logic [7:0] fv, input bit poke_start,
                         input string tag);
    int cyc = 1, busy_cnt = 0, done_at = 0, wr_cnt = 0, req_bad = 0;
    int exp_busy;
    logic [7:0] cks = 8'h00, sum = 8'h00, v;
    @(negedge clk);
    start = 1'b1; mode = m; src = s; dst = d; len = n; fill_val = fv;
    @(negedge clk);
    start = 1'b0;
    mode = 1'($urandom); src = 8'($urandom); dst = 8'($urandom);
    len = 8'($urandom); fill_val = 8'($urandom);
    while (done_at == 0 && cyc <= 700) begin
      if (busy) busy_cnt++;
      if (mem_w) wr_cnt++;
      if (mem_req !== busy) req_bad++;
      if (done) begin
        done_at = cyc;
        cks = checksum;
      end else begin
        start = (poke_start && cyc == 2) ? 1'b1 : 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;

    for (int i = 0; i < int'(n); i++) begin
      v = (m == 1'b0) ? refm[8'(int'(s) + i)] : fv;
      refm[8'(int'(d) + i)] = v;
      sum = sum + v;
    end
    exp_busy = (m == 1'b0) ? 2 * int'(n) : int'(n);

    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, "_done_cycle"}, done_at, exp_busy + 1);
    chk({tag, "_writes"}, wr_cnt, n);
    chk({tag, "_req_eq_busy"}, req_bad, 0);
    cmp_mem({tag, "_mem"});
`ifdef MEM_DMA_CHECKSUM_EN
    chk({tag, "_cksum"}, cks, sum);
`else
    chk({tag, "_cksum_tied"}, cks, 0);
`endif
  endtask

  initial begin
    logic [7:0] old3, old4, old5, old2, old01;
    int dn, wr;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    fill_val = '0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;

    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed copy.
    poke(8'h10, 8'hAA); poke(8'h11, 8'hBB); poke(8'h12, 8'hCC); poke(8'h13, 8'hDD);
    run_cmd(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 1'b0, "copy4");
    chk("copy4_b0", mem[8'h80], 8'hAA);
    chk("copy4_b3", mem[8'h83], 8'hDD);
`ifdef MEM_DMA_CHECKSUM_EN
    chk("copy4_cksum_0e", checksum, 8'h0E);
`endif

    // Fill wrapping past 0xFF.
    old01 = refm[8'h01];
    run_cmd(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, 1'b0, "fillwrap");
    chk("fillwrap_ff", mem[8'hFF], 8'h5A);
    chk("fillwrap_00", mem[8'h00], 8'h5A);
    chk("fillwrap_01_kept", mem[8'h01], old01);

    // Zero length.
    run_cmd(1'b1, 8'h00, 8'h30, 8'd0, 8'h77, 1'b0, "zero");

    // Overlapping forward copy.
    poke(8'h20, 8'h01); poke(8'h21, 8'h02);
    run_cmd(1'b0, 8'h20, 8'h22, 8'd4, 8'h00, 1'b0, "overlap");
    chk("overlap_24", mem[8'h24], 8'h01);
    chk("overlap_25", mem[8'h25], 8'h02);

    // Start pulsed while busy must not disturb the transfer.
    run_cmd(1'b1, 8'h00, 8'h50, 8'd5, 8'h3C, 1'b1, "busy_start_fill");
    run_cmd(1'b0, 8'h60, 8'h90, 8'd5, 8'h00, 1'b1, "busy_start_copy");

    // Reset during the 3rd byte of a 6-byte fill.
    old2 = refm[8'h42]; old3 = refm[8'h43]; old4 = refm[8'h44]; old5 = refm[8'h45];
    @(negedge clk);
    start = 1'b1; mode = 1'b1; dst = 8'h40; len = 8'd6; fill_val = 8'hC3;
    @(negedge clk); start = 1'b0;   // cycle 1: byte 0
    @(negedge clk);                 // cycle 2: byte 1
    @(negedge clk);                 // cycle 3: byte 2
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst_n = 1'b1;
    dn = 0; wr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (mem_w) wr++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_no_writes", wr, 0);
    chk("abort_b0", mem[8'h40], 8'hC3);
    chk("abort_b1", mem[8'h41], 8'hC3);
    chk("abort_b2_allowed", (mem[8'h42] == 8'hC3 || mem[8'h42] == old2) ? 1 : 0, 1);
    chk("abort_b3", mem[8'h43], old3);
    chk("abort_b4", mem[8'h44], old4);
    chk("abort_b5", mem[8'h45], old5);
    refm[8'h40] = 8'hC3; refm[8'h41] = 8'hC3; refm[8'h42] = mem[8'h42];

    // Randomized commands.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] rl;
      rl = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 24));
      run_cmd(1'($urandom), 8'($urandom), 8'($urandom), rl, 8'($urandom),
              1'($urandom), $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
